// File: rtl/spi_burst_arbiter.sv
// Shares one byte-level SPI master engine between two requesters, locking the
// engine to one requester for a whole burst and sequencing start/busy/done per byte.
module spi_burst_arbiter #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int TO_W         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    output logic       eng_start,
    output logic [7:0] eng_tx_data,
    input  logic       eng_busy,
    input  logic [7:0] eng_rx_data,
    output logic       owner,
    output logic       burst_active,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            rr_ptr;
    logic            last_q;
    logic [TO_W-1:0] to_cnt;

    logic elig0, elig1, grant1, can_accept, hs, to_hit, done;

    // Handshake: a byte moves on the edge where reqN_valid & reqN_ready are both high.
    always_comb begin
        elig0      = req0_valid & (~burst_active | ~owner);
        elig1      = req1_valid & (~burst_active | owner);
        // On a tie the requester that did not finish the previous burst wins.
        grant1     = elig1 & (~elig0 | ~rr_ptr);
        can_accept = (state == IDLE) & ~eng_busy & ~reset;
        req0_ready = can_accept & elig0 & ~grant1;
        req1_ready = can_accept & elig1 & grant1;
        hs         = req0_ready | req1_ready;
        to_hit     = (state == WAIT_BUSY) & ~eng_busy
                     & (to_cnt == TO_W'(BUSY_TIMEOUT - 1));
        done       = (state == WAIT_DONE) & ~eng_busy;

        state_nxt = state;
        case (state)
            IDLE:      if (hs) state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (eng_busy)    state_nxt = WAIT_DONE;
                else if (to_hit) state_nxt = IDLE;
            end
            WAIT_DONE: if (~eng_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= 1'b1;
            last_q       <= 1'b0;
            to_cnt       <= '0;
            eng_start    <= 1'b0;
            eng_tx_data  <= 8'h00;
            owner        <= 1'b0;
            burst_active <= 1'b0;
            timeout_err  <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp0_data    <= 8'h00;
            rsp1_valid   <= 1'b0;
            rsp1_data    <= 8'h00;
        end else begin
            state       <= state_nxt;
            eng_start   <= hs;
            timeout_err <= to_hit;
            rsp0_valid  <= done & ~owner;
            rsp1_valid  <= done & owner;

            if (hs) begin
                eng_tx_data  <= grant1 ? req1_data : req0_data;
                last_q       <= grant1 ? req1_last : req0_last;
                owner        <= grant1;
                burst_active <= 1'b1;
                to_cnt       <= '0;
            end

            if ((state == WAIT_BUSY) & ~eng_busy) begin
                to_cnt <= to_cnt + 1'b1;
                // An aborted burst gives up its lock; leftover bytes re-arbitrate.
                if (to_hit) begin
                    burst_active <= 1'b0;
                    rr_ptr       <= owner;
                end
            end

            if (done) begin
                if (owner) rsp1_data <= eng_rx_data;
                else       rsp0_data <= eng_rx_data;
                if (last_q) begin
                    burst_active <= 1'b0;
                    rr_ptr       <= owner;
                end
            end
        end
    end

endmodule

// File: doc/spi_burst_arbiter.md
Name: spi_burst_arbiter

Overview:
- Shares one byte-level SPI master engine between two requesters. Each requester owns the bus for a whole burst, so chip-select-level transactions never interleave.
- Sequences each byte through the engine handshake: `eng_start`, then wait for `eng_busy` high, then wait for `eng_busy` low. Returns the received byte to the burst owner.
- Sits between host-side command logic (e.g. UART bridge, register sequencer) and the SPI master.

Parameters:
- BUSY_TIMEOUT, 16: maximum cycles to wait for `eng_busy` to rise after `eng_start` before aborting the burst.
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > BUSY_TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 presents a byte to send
- req0_data  in  8  requester 0 TX byte
- req0_last  in  1  this byte ends requester 0's burst
- req0_ready  out  1  requester 0 byte accepted this cycle (valid&ready = handshake)
- rsp0_valid  out  1  one-cycle pulse, RX byte for requester 0
- rsp0_data  out  8  RX byte for requester 0
- req1_valid, req1_data, req1_last, req1_ready, rsp1_valid, rsp1_data: same as port 0, for requester 1
- eng_start  out  1  one-cycle start pulse to the SPI engine
- eng_tx_data  out  8  byte to the engine, held stable from `eng_start` until done
- eng_busy  in  1  engine transfer in progress
- eng_rx_data  in  8  engine RX byte, valid in the cycle `eng_busy` is sampled low after being high
- owner  out  1  requester currently granted (meaningful when `burst_active`=1)
- burst_active  out  1  a burst is locked to `owner`
- timeout_err  out  1  one-cycle pulse, engine failed to go busy

Behaviour:
- Reset (async, any state, including mid-burst): state=IDLE and all outputs 0. Internal state also clears: rr pointer=1 (so req0 wins the first tie) and the timeout counter=0. The lock is released.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE, eligibility:
  - `burst_active`=1: only `owner`'s `valid` is considered; the other requester's `ready` stays 0.
  - `burst_active`=0: whichever `valid` is high is eligible.
  - Both valid: grant the requester not equal to the rr pointer.
- IDLE, ready: `reqN_ready` is combinational and equals (state==IDLE) & `eng_busy`==0 & eligible & granted. At most one `ready` is high per cycle.
- Handshake at edge T. All of the following take effect at T+1, then the block moves to WAIT_BUSY:
  - `eng_tx_data` <= `reqN_data`; `eng_start`=1 for exactly one cycle.
  - `owner` <= N; `burst_active` <= 1.
  - Latch `last` <= `reqN_last`; timeout counter <= 0.
- WAIT_BUSY:
  - `eng_busy`=1 → WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches BUSY_TIMEOUT with `eng_busy` still 0:
    - `timeout_err` pulses 1 cycle, no `rsp` is issued, and `burst_active` <= 0.
    - rr pointer <= `owner`, then IDLE.
    - The requester's remaining bytes become new bursts subject to arbitration.
- WAIT_DONE:
  - `eng_busy`=0 → `rspN_data` <= `eng_rx_data` and `rspN_valid` pulses 1 cycle for N=`owner`.
  - If `last`: `burst_active` <= 0 and rr pointer <= `owner`. Then IDLE.
  - No timeout in WAIT_DONE; the engine transfer length is bounded by design.
- No response backpressure: the requester must accept `rsp` on the pulse.
- `eng_tx_data` holds its value from `eng_start` through WAIT_DONE and is not cleared afterward.
- `eng_start` is never asserted while `eng_busy`=1 or outside the handshake-following cycle.
- Requester rules:
  - A requester may drop `valid` without a handshake; no state changes.
  - A burst owner not presenting `valid` keeps the lock indefinitely. Stalls are the requester's responsibility.
- Simultaneous `valid` on both ports while locked: the non-owner waits until the owner's `last` byte completes. It is then granted in the next IDLE cycle in which it is eligible.
- Minimum per-byte occupancy: 1 (handshake) + 1 (start) + engine busy duration + 1. Back-to-back bytes of one burst are legal with no idle gap beyond that.

Test Plan:
- Single byte: req0 sends 0xA5 with last=1; engine model goes busy 2 cycles after start and stays busy 16 cycles, returning 0x3C → one `eng_start`, `eng_tx_data`=0xA5, `rsp0_valid` with 0x3C, `burst_active` back to 0, `rsp1_valid` never fires.
- Tie: both valid at the same edge after reset, each with a 1-byte burst → req0 granted first, then req1. Repeat the tie → req0 again (rr pointer alternates after each completion).
- Burst lock: req0 sends a 3-byte burst (0x01, 0x02, 0x03 last) while req1 holds valid with 0xFF → `req1_ready`=0 until req0's third `rsp0_valid`. Then req1 is granted, giving exactly four `eng_start` pulses in the order 01, 02, 03, FF.
- Timeout: engine model never raises busy → `timeout_err` pulses exactly BUSY_TIMEOUT=16 cycles into WAIT_BUSY, no `rsp`, `burst_active`=0, and a pending req1 is then granted.
- Reset mid-burst: assert `reset` during WAIT_DONE of byte 2 of a 4-byte req1 burst → all outputs 0 immediately. After release, req0 wins a tie, and no stale `rsp1_valid` appears.
- Protocol check (assertion): `eng_start` is never high while `eng_busy` is high; at most one `ready` per cycle; `rspN_valid` is only ever issued for the current `owner`.
